// File: rtl/riscv_power_estimator.sv
// riscv_power_estimator: runtime activity-based energy estimator.
// Counts per-channel activity events over a programmable window. At each window
// end the counts are snapshotted and a sequential reducer computes
//   base * eff_win + sum_k(count[k] * weight[k])
// one channel per cycle, then publishes the saturated result and an
// over-budget flag for the power-management / DVFS logic.
// Optional feature macro: RISCV_PWR_EST_THROTTLE_EN (hysteretic throttle_o).
module riscv_power_estimator #(
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 16,
  parameter int WEIGHT_W = 8,
  parameter int WIN_W    = 16,
  parameter int BASE_W   = 16,
  parameter int ACC_W    = 48,
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [NUM_CH-1:0]   evt_i,
  input  logic [WIN_W-1:0]    window_len_i,
  input  logic [BASE_W-1:0]   base_i,
  input  logic [ACC_W-1:0]    budget_i,
  input  logic                cfg_we_i,
  input  logic [IDX_W-1:0]    cfg_idx_i,
  input  logic [WEIGHT_W-1:0] cfg_wdata_i,
  output logic [ACC_W-1:0]    result_o,
  output logic                result_valid_o,
  output logic                over_budget_o,
  output logic                busy_o,
  output logic                throttle_o
);

  localparam int MIN_WIN = NUM_CH + 2;
  localparam int PROD_W  = CNT_W + WEIGHT_W;
  localparam int BP_W    = BASE_W + WIN_W;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_ACC  = 1'b1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_MAC  = 2'd1;
  localparam logic [1:0] R_PUB  = 2'd2;

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  // Event counter increment that sticks at its maximum value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             e);
    return (e && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
  endfunction

  logic [0:0]          r_wstate;
  logic [WIN_W-1:0]    r_wcnt;
  logic [WIN_W-1:0]    r_effwin;
  logic [BASE_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_cnt    [NUM_CH];
  logic [CNT_W-1:0]    r_shadow [NUM_CH];
  logic [WEIGHT_W-1:0] r_weight [NUM_CH];

  logic [1:0]          r_rstate;
  logic [IDX_W-1:0]    r_k;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_result;
  logic                r_valid;
  logic                r_over;

  logic [WIN_W-1:0]    w_win_len_eff;
  logic                w_start;
  logic                w_last_k;
  logic [PROD_W-1:0]   w_prod;
  logic [BP_W-1:0]     w_base_prod;
  logic [ACC_W-1:0]    w_acc_mac;

  // Short windows are stretched so the reducer always drains before the next snapshot.
  assign w_win_len_eff = (window_len_i < WIN_W'(MIN_WIN)) ? WIN_W'(MIN_WIN) : window_len_i;
  assign w_start       = (r_wstate == W_ACC) && enable_i && (r_wcnt == r_effwin - 1'b1);
  assign w_last_k      = (r_k == IDX_W'(NUM_CH - 1));
  assign w_prod        = PROD_W'(r_shadow[r_k]) * PROD_W'(r_weight[r_k]);
  assign w_base_prod   = BP_W'(r_base) * BP_W'(r_effwin);
  assign w_acc_mac     = sat_add(r_acc, ACC_W'(w_prod));

  // Window sequencer: count events per channel and snapshot them at window end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_effwin <= '0;
      r_base   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_cnt[k]    <= '0;
        r_shadow[k] <= '0;
      end
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (enable_i) begin
            r_wstate <= W_ACC;
            r_wcnt   <= '0;
            r_effwin <= w_win_len_eff;
            r_base   <= base_i;
          end
        end
        W_ACC: begin
          if (!enable_i) begin
            // Partial window is dropped without publishing.
            r_wstate <= W_IDLE;
            r_wcnt   <= '0;
            for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
          end else if (w_start) begin
            // Last cycle's events are folded into the snapshot; next window starts now.
            for (int k = 0; k < NUM_CH; k++) begin
              r_shadow[k] <= sat_inc(r_cnt[k], evt_i[k]);
              r_cnt[k]    <= '0;
            end
            r_wcnt   <= '0;
            r_effwin <= w_win_len_eff;
            r_base   <= base_i;
          end else begin
            for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= sat_inc(r_cnt[k], evt_i[k]);
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Reducer: seed with base cost, MAC one channel per cycle, then publish.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rstate <= R_IDLE;
      r_k      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_rstate)
        R_IDLE: begin
          if (w_start) begin
            // Uses the base/length latched for the window that is just ending.
            r_acc    <= ACC_W'(w_base_prod);
            r_k      <= '0;
            r_rstate <= R_MAC;
          end
        end
        R_MAC: begin
          r_acc <= w_acc_mac;
          if (w_last_k) begin
            r_result <= w_acc_mac;
            r_valid  <= 1'b1;
            r_over   <= (w_acc_mac > budget_i);
            r_rstate <= R_PUB;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        R_PUB:   r_rstate <= R_IDLE;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Weight table; out-of-range indices are ignored, MAC sees the pre-write value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) r_weight[k] <= '0;
    end else if (cfg_we_i && ({1'b0, cfg_idx_i} < (IDX_W + 1)'(NUM_CH))) begin
      r_weight[cfg_idx_i] <= cfg_wdata_i;
    end
  end

`ifdef RISCV_PWR_EST_THROTTLE_EN
  logic r_throttle;

  // Throttle request with a 12.5% hysteresis band below the budget.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_throttle <= 1'b0;
    end else if ((r_rstate == R_MAC) && w_last_k) begin
      if (w_acc_mac > budget_i) begin
        r_throttle <= 1'b1;
      end else if (w_acc_mac < (budget_i - (budget_i >> 3))) begin
        r_throttle <= 1'b0;
      end
    end
  end

  assign throttle_o = r_throttle;
`else
  assign throttle_o = 1'b0;
`endif

  assign result_o       = r_result;
  assign result_valid_o = r_valid;
  assign over_budget_o  = r_over;
  assign busy_o         = (r_rstate != R_IDLE);

endmodule

// File: tb/tb_riscv_power_estimator.sv
// Bench for riscv_power_estimator: NUM_CH=4 main instance plus a CNT_W=4
// instance sharing the same stimulus to exercise counter saturation.
// Expected publishes are queued when a window is driven and checked on result_valid_o.
module tb_riscv_power_estimator;

  localparam int N     = 4;
  localparam int ACC_W = 48;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              enable_i;
  logic [N-1:0]      evt_i;
  logic [15:0]       window_len_i;
  logic [15:0]       base_i;
  logic [ACC_W-1:0]  budget_i;
  logic              cfg_we_i;
  logic [1:0]        cfg_idx_i;
  logic [7:0]        cfg_wdata_i;

  logic [ACC_W-1:0]  result_o,       s_result_o;
  logic              result_valid_o, s_result_valid_o;
  logic              over_budget_o,  s_over_budget_o;
  logic              busy_o,         s_busy_o;
  logic              throttle_o,     s_throttle_o;

  riscv_power_estimator #(.NUM_CH(N)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .evt_i(evt_i),
    .window_len_i(window_len_i), .base_i(base_i), .budget_i(budget_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_wdata_i(cfg_wdata_i),
    .result_o(result_o), .result_valid_o(result_valid_o),
    .over_budget_o(over_budget_o), .busy_o(busy_o), .throttle_o(throttle_o)
  );

  riscv_power_estimator #(.NUM_CH(N), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .evt_i(evt_i),
    .window_len_i(window_len_i), .base_i(base_i), .budget_i(budget_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_wdata_i(cfg_wdata_i),
    .result_o(s_result_o), .result_valid_o(s_result_valid_o),
    .over_budget_o(s_over_budget_o), .busy_o(s_busy_o), .throttle_o(s_throttle_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ACC_W-1:0] res;
    logic [ACC_W-1:0] res_sat;
    logic             over;
    int               due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pubs   = 0;
  int   w[N];
  logic thr_model = 1'b0;

  // Publish monitor: pops the scoreboard and compares every published field.
  always @(negedge clk) begin
    if (result_valid_o === 1'b1) begin
      pubs++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_publish: got result=%0d, expected no publish", result_o);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (result_o !== mon_e.res) begin
          errors++;
          $display("FAIL result: got %0d, expected %0d", result_o, mon_e.res);
        end
        checks++;
        if (s_result_o !== mon_e.res_sat) begin
          errors++;
          $display("FAIL sat_result: got %0d, expected %0d", s_result_o, mon_e.res_sat);
        end
        checks++;
        if (over_budget_o !== mon_e.over) begin
          errors++;
          $display("FAIL over_budget: got %b, expected %b", over_budget_o, mon_e.over);
        end
        checks++;
        if (cyc !== mon_e.due) begin
          errors++;
          $display("FAIL publish_cycle: got %0d, expected %0d", cyc, mon_e.due);
        end
        checks++;
        if (s_result_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL sat_valid: got %b, expected 1", s_result_valid_o);
        end
`ifdef RISCV_PWR_EST_THROTTLE_EN
        if (mon_e.res > budget_i) thr_model = 1'b1;
        else if (mon_e.res < (budget_i - (budget_i >> 3))) thr_model = 1'b0;
`else
        thr_model = 1'b0;
`endif
        checks++;
        if (throttle_o !== thr_model) begin
          errors++;
          $display("FAIL throttle: got %b, expected %b", throttle_o, thr_model);
        end
      end
    end else if (s_result_valid_o === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL sat_valid_alone: got 1, expected 0");
    end
  end

  task automatic set_weights(input int a, input int b, input int c, input int d);
    int v[N] = '{a, b, c, d};
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      cfg_we_i    = 1'b1;
      cfg_idx_i   = 2'(k);
      cfg_wdata_i = 8'(v[k]);
      w[k]        = v[k];
    end
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  task automatic start_win(input int len, input int base);
    @(negedge clk);
    window_len_i = 16'(len);
    base_i       = 16'(base);
    enable_i     = 1'b1;
  endtask

  // Drives one full window (eff_win cycles) and queues its expected publish.
  task automatic run_window(input int len, input int base,
                            input int e0, input int e1, input int e2, input int e3,
                            input int nlen, input int nbase);
    int ev[N] = '{e0, e1, e2, e3};
    int eff;
    longint unsigned acc, accs;
    exp_t e;
    eff = (len < N + 2) ? N + 2 : len;
    e.due = 0;
    for (int j = 0; j < eff; j++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) evt_i[k] = (j < ev[k]);
      if (j == eff - 1) begin
        window_len_i = 16'(nlen);
        base_i       = 16'(nbase);
        e.due        = cyc + N + 1;
      end
    end
    acc  = longint'(base) * longint'(eff);
    accs = acc;
    for (int k = 0; k < N; k++) begin
      acc  += longint'((ev[k] > 65535) ? 65535 : ev[k]) * longint'(w[k]);
      accs += longint'((ev[k] > 15) ? 15 : ev[k]) * longint'(w[k]);
    end
    e.res     = ACC_W'(acc);
    e.res_sat = ACC_W'(accs);
    e.over    = (ACC_W'(acc) > budget_i);
    sb.push_back(e);
  endtask

  task automatic stop_win();
    @(negedge clk);
    enable_i = 1'b0;
    evt_i    = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending publishes, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b0; evt_i = '0; window_len_i = '0; base_i = '0;
    budget_i = '0; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_wdata_i = '0;
    thr_model = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (result_o !== '0) begin errors++; $display("FAIL reset_result: got %0d, expected 0", result_o); end
    checks++;
    if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", result_valid_o); end
    checks++;
    if (over_budget_o !== 1'b0) begin errors++; $display("FAIL reset_over: got %b, expected 0", over_budget_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
    checks++;
    if (throttle_o !== 1'b0) begin errors++; $display("FAIL reset_throttle: got %b, expected 0", throttle_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    set_weights(1, 2, 3, 4);
    budget_i = 48'd1000;
    start_win(16, 10);
    run_window(16, 10, 16, 0, 0, 4, 16, 10);
    stop_win();
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, expected 1", busy_o); end
    drain();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b, expected 0", busy_o); end
  endtask

  task automatic test_min_window();
    budget_i = 48'd1000;
    start_win(2, 1);
    run_window(2, 1, 0, 0, 0, 0, 2, 1);
    run_window(2, 1, 0, 0, 0, 0, 2, 1);
    run_window(2, 1, 0, 0, 0, 0, 2, 1);
    stop_win();
    drain();
  endtask

  task automatic test_saturation();
    set_weights(1, 0, 0, 0);
    budget_i = 48'd100;
    start_win(32, 0);
    run_window(32, 0, 32, 0, 0, 0, 32, 0);
    stop_win();
    drain();
  endtask

  task automatic test_back_to_back();
    set_weights(1, 2, 3, 4);
    budget_i = 48'd100;
    start_win(16, 10);
    run_window(16, 10, 16, 0, 0, 4, 16, 3);
    run_window(16, 3, 0, 0, 0, 0, 16, 3);
    stop_win();
    drain();
  endtask

  task automatic test_throttle();
    budget_i = 48'd160;
    start_win(16, 10);
    run_window(16, 10, 16, 0, 0, 4, 16, 9);
    run_window(16, 9, 6, 0, 0, 0, 16, 8);
    run_window(16, 8, 2, 0, 0, 0, 16, 8);
    stop_win();
    drain();
  endtask

  task automatic test_abort();
    int p0;
    budget_i = 48'd1000;
    start_win(16, 10);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      evt_i = 4'b1001;
    end
    stop_win();
    p0 = pubs;
    repeat (25) @(negedge clk);
    checks++;
    if (pubs !== p0) begin errors++; $display("FAIL abort_publish: got %0d publishes, expected %0d", pubs, p0); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy_o); end
    start_win(16, 10);
    run_window(16, 10, 16, 0, 0, 4, 16, 10);
    stop_win();
    drain();
  endtask

  task automatic test_reset_mid();
    int p0;
    budget_i = 48'd1000;
    start_win(16, 10);
    run_window(16, 10, 16, 0, 0, 4, 16, 10);
    stop_win();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, expected 1", busy_o); end
    rst_i = 1'b1;
    sb.delete();
    thr_model = 1'b0;
    p0 = pubs;
    @(negedge clk);
    checks++;
    if (result_o !== '0) begin errors++; $display("FAIL mid_reset_result: got %0d, expected 0", result_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b, expected 0", busy_o); end
    checks++;
    if (result_valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b, expected 0", result_valid_o); end
    rst_i = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (pubs !== p0) begin errors++; $display("FAIL mid_reset_publish: got %0d publishes, expected %0d", pubs, p0); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) w[k] = 0;
    test_reset();
    test_basic();
    test_min_window();
    test_saturation();
    test_back_to_back();
    test_throttle();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/riscv_power_estimator.md
Name: riscv_power_estimator

Overview:
Runtime activity-based power/energy estimator, the successor to the static compile-time area/power estimate functions in the core package. Counts per-unit activity events (ROB, RS, ALU, MUL, DIV, BTB, ...) over a programmable window. At each window end it computes a weighted energy figure: base cost plus the sum over channels of count times weight. Result and an over-budget flag feed the core's power-management / DVFS logic.

Parameters:
NUM_CH, 8, number of activity channels (1..32)
CNT_W, 16, per-channel event counter width (saturating)
WEIGHT_W, 8, per-channel energy weight width (unsigned)
WIN_W, 16, window length register width
BASE_W, 16, per-cycle base cost width
ACC_W, 48, result/accumulator width (saturating)

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  estimator run enable
evt_i  in  NUM_CH  per-channel event pulse, one event per asserted cycle
window_len_i  in  WIN_W  requested window length in cycles
base_i  in  BASE_W  static cost per cycle
budget_i  in  ACC_W  energy budget per window
cfg_we_i  in  1  weight write strobe
cfg_idx_i  in  $clog2(NUM_CH) (min 1)  weight index
cfg_wdata_i  in  WEIGHT_W  weight value
result_o  out  ACC_W  last published window energy
result_valid_o  out  1  one-cycle pulse when result_o updates
over_budget_o  out  1  result_o > budget_i at last publish
busy_o  out  1  reduction in progress
throttle_o  out  1  throttle request (see Optional Feature)

Behaviour:
- Single clock domain clk_i; rst_i synchronous, active-high.
- Reset: all counters, shadows and weights = 0; result_o = 0; all flags = 0; both FSMs idle.
- Window FSM, states W_IDLE and W_ACC:
  - W_IDLE -> W_ACC on the first cycle enable_i = 1.
  - On entry: eff_win = max(window_len_i, NUM_CH+2) latched; base_i latched; window counter = 0.
  - W_ACC, each cycle: cnt[k] += evt_i[k], saturating at 2^CNT_W-1.
  - Last window cycle (counter = eff_win-1), events of that cycle included: cnt copied to shadow[] and cleared; reducer started.
  - Next window starts immediately with a fresh eff_win/base latch. No cycle is lost between windows.
  - enable_i = 0 in W_ACC: -> W_IDLE; live counts cleared; partial window discarded, never published.
- Reducer FSM, states R_IDLE, R_MAC, R_PUB:
  - Start: acc = base_latched * eff_win; -> R_MAC; busy_o = 1.
  - R_MAC: one channel per cycle, k = 0..NUM_CH-1, acc += shadow[k] * weight[k]; NUM_CH cycles.
  - R_PUB: result_o = acc; result_valid_o pulses; over_budget_o = (acc > budget_i), held until next publish; -> R_IDLE.
  - Latency: result_valid_o asserts NUM_CH+1 cycles after the window's last cycle.
  - eff_win >= NUM_CH+2 guarantees the reducer is idle before the next snapshot.
  - An in-flight reduction completes and publishes even if enable_i drops.
- Arithmetic: all unsigned. Products are full width. acc saturates at 2^ACC_W-1 and never wraps.
- Weight writes:
  - cfg_we_i writes weight[cfg_idx_i] at the clock edge.
  - cfg_idx_i >= NUM_CH is ignored.
  - The MAC reads the register value current in its cycle. A write and a read of the same index in the same cycle uses the old value.

Optional Feature:
Macro RISCV_PWR_EST_THROTTLE_EN.
- Defined: throttle_o sets at publish when result > budget_i. It clears at publish when result < budget_i - (budget_i >> 3), a 12.5% hysteresis band. Otherwise it holds. Reset value 0.
- Undefined: throttle_o tied 0; no hysteresis logic is synthesised.

Test Plan:
- Basic result: NUM_CH=4, weights {1,2,3,4}, base=10, window=16. ch0 pulses all 16 cycles, ch3 pulses 4 cycles -> result_o = 160+16+16 = 192; result_valid_o pulses 5 cycles after the window's last cycle.
- Minimum window clamp: NUM_CH=4, window_len_i=2, base=1, no events -> windows of 6 cycles; result_o = 6, one pulse every 6 cycles.
- Counter saturation: CNT_W=4, weight=1, base=0, window=32, continuous ch0 events -> result_o = 15.
- Budget flag and back-to-back windows: budget=100. Window A as in the basic test -> over_budget_o = 1. Immediately following window B with no events, base=3 -> result 48, over_budget_o = 0. No gap cycles between windows.
- Abort and reset: enable_i drops at window cycle 8 -> no publish. Re-enable -> fresh window, count starts from 0. Assert rst_i during R_MAC -> next cycle result_o = 0, busy_o = 0, no result_valid_o pulse.
- Throttle (macro defined): budget=160, publishes of 192, 150, 130 -> throttle_o = 1, 1 (inside hysteresis band), 0.
